sopc_bus_arbiter: RTL and testbench

SOPC_BUS_ARBITER -- requirements
Module: sopc_bus_arbiter

---
 rtl/sopc_pkg.sv | 15 +
 rtl/sopc_rr_pick.sv | 19 +
 rtl/sopc_bus_arbiter.sv | 119 +++++++++++
 tb/tb_sopc_bus_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sopc_pkg.sv
// Shared definitions for the two-master SOPC bus arbiter: state encoding and
// default parameter values.
package sopc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sopc_rr_pick.sv
// Two-way round-robin pick: on a tie the master not served last wins.
// Purely combinational, one-hot grant out.
module sopc_rr_pick (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_served ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sopc_bus_arbiter.sv
// Two-master (CPU data port, UART loader) arbiter onto a single shared slave bus,
// with round-robin tie-break and slave-ack timeout completion.
module sopc_bus_arbiter
  import sopc_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_ack,
  output logic                m0_err,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_be,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                grant
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state;
  logic             last_served;
  logic [1:0]       pick;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  sopc_rr_pick u_pick (
    .req         ({m1_req, m0_req}),
    .last_served (last_served),
    .gnt         (pick)
  );

  // The counter "reaches TIMEOUT" on the edge where it would step to TIMEOUT,
  // so a silent slave yields exactly TIMEOUT BUSY cycles.
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
      cnt         <= '0;
      grant       <= 1'b0;
      s_req       <= 1'b0;
      s_we        <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_be        <= '0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= '0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick != 2'b00) begin
            grant   <= pick[1];
            s_req   <= 1'b1;
            s_we    <= pick[1] ? m1_we    : m0_we;
            s_addr  <= pick[1] ? m1_addr  : m0_addr;
            s_wdata <= pick[1] ? m1_wdata : m0_wdata;
            s_be    <= pick[1] ? m1_be    : m0_be;
            cnt     <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ack || timeout_hit) begin
            s_req <= 1'b0;
            state <= ST_DONE;
            if (grant) begin
              m1_ack   <= 1'b1;
              m1_err   <= ~s_ack;
              m1_rdata <= s_ack ? s_rdata : '0;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= ~s_ack;
              m0_rdata <= s_ack ? s_rdata : '0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          last_served <= grant;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// Directed self-checking bench for sopc_bus_arbiter: table of single transfers
// plus hand sequences for round-robin, reset mid-transfer and stray slave acks.
module tb_sopc_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_be, m1_be;
  logic            m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            s_req, s_we, s_ack;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [DW/8-1:0] s_be;
  logic            grant;

  int checks = 0;
  int errors = 0;

  sopc_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  // k = BUSY cycle (1-based) in which the slave acks; 0 = slave never acks
  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          k;
    logic [31:0] srd;
    int          exp_busy;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    int   busy = 0;
    int   cyc = 0;
    bit   got = 0;
    bit   fields_ok = 1;
    bit   other = 0;
    logic e = 1'b0;
    logic [31:0] rd = '0;
    @(negedge clk);
    if (!v.mst) begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_be = v.be;
    end else begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_be = v.be;
    end
    s_ack = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (v.mst ? m0_ack : m1_ack) other = 1;
      if (v.mst ? m1_ack : m0_ack) begin
        got = 1;
        e   = v.mst ? m1_err : m0_err;
        rd  = v.mst ? m1_rdata : m0_rdata;
      end else if (s_req) begin
        busy++;
        if (s_we !== v.we || s_addr !== v.addr || s_wdata !== v.wdata ||
            s_be !== v.be || grant !== v.mst)
          fields_ok = 0;
        s_ack   = (busy == v.k);
        s_rdata = v.srd;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    chk({tag, " ack_seen"}, 32'(got), 32'd1);
    chk({tag, " busy_cycles"}, 32'(busy), 32'(v.exp_busy));
    chk({tag, " err"}, 32'(e), 32'(v.exp_err));
    chk({tag, " rdata"}, rd, v.exp_rdata);
    chk({tag, " slave_fields"}, 32'(fields_ok), 32'd1);
    chk({tag, " other_ack"}, 32'(other), 32'd0);
    chk({tag, " s_req_low_after"}, 32'(s_req), 32'd0);
    @(negedge clk);
    chk({tag, " ack_one_pulse"}, {30'd0, m1_ack, m0_ack}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 2, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h4000_0000, 32'h0000_00A5, 4'h1, 3, 32'h0000_1234, 3, 1'b0, 32'h0000_1234};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 0, 32'h1111_1111, 8, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'hF, 8, 32'hCAFE_F00D, 8, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0,         4'h3, 1, 32'h55AA_55AA, 1, 1'b0, 32'h55AA_55AA};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0008, 32'h0,         4'hC, 0, 32'h7777_7777, 8, 1'b1, 32'h0};

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    s_ack = 0; s_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset s_req", 32'(s_req), 32'd0);
    chk("reset acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset m0_rdata", m0_rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));
    chk("m0_rdata held", m0_rdata, 32'hCAFE_F00D);
    chk("m1_rdata after timeout", m1_rdata, 32'h0);

    // Stray slave acks while idle must not complete anything.
    @(negedge clk);
    s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("stray s_ack acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("stray s_ack m0_rdata", m0_rdata, 32'hCAFE_F00D);
    s_ack = 1'b0;

    // Round-robin from reset with both masters requesting continuously.
    begin
      int order[4];
      int n = 0;
      int cyc = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_be = 4'hF;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_be = 4'hF;
      s_rdata = 32'h0000_0042;
      while (n < 4 && cyc < 80) begin
        @(negedge clk);
        cyc++;
        if (m0_ack || m1_ack) begin
          order[n] = (m0_ack && m1_ack) ? 2 : (m1_ack ? 1 : 0);
          n++;
        end
        s_ack = s_req;
      end
      m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
      chk("rr ack count", 32'(n), 32'd4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rr order[%0d]", i), (i < n) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));
      repeat (2) @(negedge clk);
    end

    // Reset asserted in BUSY abandons the transfer without an ack.
    begin
      int cyc = 0;
      bit stray = 0;
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300; m0_be = 4'hF;
      while (!s_req && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      chk("rst_mid busy reached", 32'(s_req), 32'd1);
      @(negedge clk);
      rst = 1'b1; m0_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid s_req", 32'(s_req), 32'd0);
      chk("rst_mid grant", 32'(grant), 32'd0);
      for (int i = 0; i < 3; i++) begin
        if (m0_ack || m1_ack) stray = 1;
        @(negedge clk);
      end
      chk("rst_mid no ack", 32'(stray), 32'd0);
      do_xfer('{1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D},
              "after_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
